fpu_addsub_arbiter: RTL and testbench
=====================================

# fpu_addsub_arbiter

Shares one fixed-latency pipelined floating-point add/sub datapath among `NREQ` requesters. Each cycle, round-robin arbitration issues at most one accepted operation into the datapath, and a shadow valid/ID pipeline tracks it. Results are collected into a response FIFO with backpressure. A credit counter guarantees that no result leaving the datapath is ever dropped. The block sits between the FPU request ports of client units and the add/sub pipeline.

## Interface
- `WIDTH`, 32: operand/result width.
- `NREQ`, 4: number of requesters.
- `ID_W`, 2: requester ID width; equals clog2(`NREQ`).
- `PIPE_LAT`, 5: datapath latency, from operands registered at its inputs to `fpu_r` valid.
- `FIFO_DEPTH`, 8: response FIFO entries; must be ≥ `PIPE_LAT`+1.

- `clk` in 1: the single clock.
- `arst_n` in 1: reset, synchronous and active-low.
- `req_valid` in `NREQ`: per-requester request valid.
- `req_ready` out `NREQ`: per-requester accept; one-hot or zero.
- `req_a` in `NREQ`*`WIDTH`: operand A; requester i occupies slice [i*`WIDTH` +: `WIDTH`].
- `req_b` in `NREQ`*`WIDTH`: operand B, packed the same way.
- `req_op` in `NREQ`: 0 = add, 1 = subtract.
- `fpu_a` out `WIDTH`, registered: datapath operand A.
- `fpu_b` out `WIDTH`, registered: datapath operand B.
- `fpu_op` out 1, registered: datapath operation select.
- `fpu_r` in `WIDTH`: datapath result.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_id` out `ID_W`: index of the requester that issued the operation.
- `rsp_r` out `WIDTH`: result.
- `busy` out 1: high if any operation is in flight or buffered.

## Operation
- **Credits.** `credit` counter, range 0..`FIFO_DEPTH`, reset value `FIFO_DEPTH`.
  - Decrement on issue; increment on FIFO pop (`rsp_valid && rsp_ready`).
  - Issue and pop in the same cycle leave it unchanged.
  - Never underflows or overflows.
- **Arbitration.** Round-robin with pointer `last`, reset value `NREQ`-1.
  - Search order is `last`+1, `last`+2, … modulo `NREQ`.
  - The first requester with `req_valid` set wins, provided `credit` > 0.
  - `req_ready[w]`=1 only for that winner; all other bits are 0.
  - `req_ready` depends combinationally on `req_valid`; requesters must not make `req_valid` depend on `req_ready`.
  - Handshake is `req_valid[i] && req_ready[i]`. On a handshake, `last` ← i.
  - With no grant, `last` holds.
  - `credit`=0 forces `req_ready`=0.
- **Issue register.** On a grant, `fpu_a/fpu_b/fpu_op` ← the winner's operands at the clock edge.
  - Otherwise they hold their previous values; the datapath computes garbage, which is ignored.
  - Reset value: all zero.
- **Shadow pipeline.** `PIPE_LAT`+1 stages of {valid, id}.
  - Stage 0 captures {grant, winner id}.
  - Stage `PIPE_LAT` aligns with `fpu_r`.
  - All valid bits clear on reset.
  - Because the datapath's own reset is independent, stale datapath output after reset is discarded.
- **Response FIFO.** Synchronous, first-word-fall-through, `FIFO_DEPTH` entries of {id, result}.
  - Push when the last shadow stage is valid.
  - Pop on `rsp_valid && rsp_ready`.
  - Simultaneous push and pop when full or empty is legal.
  - Push-when-full cannot occur, because of credits; the bench asserts this.
  - `rsp_valid` = FIFO not empty.
- **busy** = (`credit` != `FIFO_DEPTH`).
- **Mid-operation reset.** Clears `credit`, `last`, shadow valids, FIFO pointers, and the issue register in the same edge. In-flight operations are lost and their results are never reported.

## Timing
- Handshake in cycle T:
  - `fpu_*` show the operands in cycle T+1.
  - `fpu_r` is valid in cycle T+1+`PIPE_LAT`.
  - It is pushed at the end of that cycle.
  - `rsp_valid` rises no earlier than T+2+`PIPE_LAT`, i.e. minimum latency `PIPE_LAT`+2 = 7 cycles at defaults.
- **Throughput.** One issue per cycle sustained while `rsp_ready`=1.
- **Backpressure.** With `rsp_ready`=0, exactly `FIFO_DEPTH` operations are accepted, then `req_ready` stays 0. One pop re-enables one grant in the next cycle.
- **Ordering.** Responses return in issue order. IDs interleave according to the round-robin order.
- **Reset values.** `req_ready`=0 during reset; all outputs are 0, except that `rsp_r`/`rsp_id` are 0 from the empty FIFO.

## Structure
- Shared package `fpu_pkg` holds:
  - `ADDSUB_LAT` = 5, the add/sub datapath latency, used as the `PIPE_LAT` default;
  - the op encodings `OP_ADD` = 0 and `OP_SUB` = 1.
- One natural sub-module: `sync_fifo` (parameters `WIDTH`, `DEPTH`; first-word-fall-through; synchronous active-low reset; `full`/`empty`/count outputs).
- The arbiter, credit counter, and shadow pipeline are inline.

## Test plan
- **Single add.** Requester 2 sends a=0x3F800000, b=0x40000000, op=0, with `rsp_ready`=1 → `rsp_valid` exactly 7 cycles later, `rsp_id`=2, `rsp_r`=0x40400000.
- **Single subtract.** Requester 0 sends 0x40400000 − 0x3F800000 → `rsp_r`=0x40000000, `rsp_id`=0.
- **Fairness.** All 4 requesters held valid for 8 cycles after reset → grants 0,1,2,3,0,1,2,3 with one grant per cycle; responses carry IDs in the same order.
- **Backpressure.** `rsp_ready`=0 with continuous requests → exactly 8 accepts, then `req_ready`=0 indefinitely. Raise `rsp_ready` for 1 cycle → exactly one further accept. No FIFO overflow assertion fires.
- **Simultaneous issue and pop at credit 0.** `credit` stays 0 and no grant occurs in that cycle; the grant occurs in the following cycle.
- **Reset mid-flight.** Assert reset for 1 cycle with 3 operations in flight → `busy`=0 and `rsp_valid`=0 after the reset cycle; no responses appear over the next 10 cycles; a new request afterwards completes normally with latency 7.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared definitions for the floating-point add/sub datapath and its front end.
package fpu_pkg;

   localparam int ADDSUB_LAT = 5;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } fpu_op_e;

endpackage : fpu_pkg

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO: the head entry is visible on dout
// whenever the FIFO is not empty; dout reads as zero when it is empty.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8,
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             push_ok;
   logic             pop_ok;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign pop_ok  = pop && !empty;
   // A full FIFO can still take a push in the same cycle as a pop.
   assign push_ok = push && (!full || pop_ok);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
      end
      if (push_ok && !pop_ok) begin
         count_d = count_q + CW'(1);
      end else if (!push_ok && pop_ok) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr_q] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (!arst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign dout  = empty ? '0 : mem[rd_ptr_q];
   assign count = count_q;

endmodule : sync_fifo

// File: rtl/fpu_addsub_arbiter.sv
// Round-robin front end sharing one fixed-latency add/sub pipeline between
// NREQ requesters, with credit-protected response buffering.
module fpu_addsub_arbiter
   import fpu_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int NREQ       = 4,
   parameter int ID_W       = 2,
   parameter int PIPE_LAT   = ADDSUB_LAT,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  arst_n,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   input  logic [NREQ-1:0]       req_op,
   output logic [WIDTH-1:0]      fpu_a,
   output logic [WIDTH-1:0]      fpu_b,
   output logic                  fpu_op,
   input  logic [WIDTH-1:0]      fpu_r,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [ID_W-1:0]       rsp_id,
   output logic [WIDTH-1:0]      rsp_r,
   output logic                  busy
);

   localparam int CRW = $clog2(FIFO_DEPTH + 1);
   localparam int FW  = ID_W + WIDTH;

   logic [CRW-1:0]   credit_q, credit_d;
   logic [ID_W-1:0]  last_q, last_d;
   logic [WIDTH-1:0] fpu_a_q, fpu_a_d;
   logic [WIDTH-1:0] fpu_b_q, fpu_b_d;
   logic             fpu_op_q, fpu_op_d;
   logic [PIPE_LAT:0] sh_vld_q;
   logic [ID_W-1:0]  sh_id_q [PIPE_LAT+1];

   logic             grant_any;
   logic [ID_W-1:0]  grant_id;
   logic [ID_W-1:0]  cand_id;
   logic             issue;
   logic             rsp_pop;
   logic             res_push;
   logic             fifo_push;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CRW-1:0]   fifo_count;
   logic [FW-1:0]    fifo_dout;

   // Search starts one past the last winner; a zero credit means no slot is
   // left in the response FIFO for another result, so nothing is granted.
   always_comb begin
      grant_any = 1'b0;
      grant_id  = '0;
      cand_id   = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand_id = ID_W'((int'(last_q) + k) % NREQ);
         if (!grant_any && req_valid[cand_id]) begin
            grant_any = 1'b1;
            grant_id  = cand_id;
         end
      end
      if (!arst_n || credit_q == '0) begin
         grant_any = 1'b0;
      end
   end

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
      assign req_ready[gi] = grant_any && (grant_id == ID_W'(gi));
   end

   assign issue   = grant_any;
   assign rsp_pop = rsp_valid && rsp_ready;

   always_comb begin
      credit_d = credit_q;
      last_d   = last_q;
      fpu_a_d  = fpu_a_q;
      fpu_b_d  = fpu_b_q;
      fpu_op_d = fpu_op_q;
      if (issue && !rsp_pop) begin
         credit_d = credit_q - CRW'(1);
      end else if (!issue && rsp_pop) begin
         credit_d = credit_q + CRW'(1);
      end
      if (issue) begin
         last_d   = grant_id;
         fpu_a_d  = req_a[int'(grant_id)*WIDTH +: WIDTH];
         fpu_b_d  = req_b[int'(grant_id)*WIDTH +: WIDTH];
         fpu_op_d = req_op[grant_id];
      end
   end

   always_ff @(posedge clk) begin
      if (!arst_n) begin
         credit_q <= CRW'(FIFO_DEPTH);
         last_q   <= ID_W'(NREQ - 1);
         fpu_a_q  <= '0;
         fpu_b_q  <= '0;
         fpu_op_q <= 1'b0;
      end else begin
         credit_q <= credit_d;
         last_q   <= last_d;
         fpu_a_q  <= fpu_a_d;
         fpu_b_q  <= fpu_b_d;
         fpu_op_q <= fpu_op_d;
      end
   end

   // Shadow of the datapath: stage PIPE_LAT lines up with fpu_r. Only the
   // valids are reset, so stale datapath output after reset is never pushed.
   always_ff @(posedge clk) begin
      if (!arst_n) begin
         sh_vld_q <= '0;
      end else begin
         sh_vld_q <= {sh_vld_q[PIPE_LAT-1:0], issue};
      end
      sh_id_q[0] <= grant_id;
      for (int k = 1; k <= PIPE_LAT; k++) begin
         sh_id_q[k] <= sh_id_q[k-1];
      end
   end

   assign res_push  = sh_vld_q[PIPE_LAT];
   assign fifo_push = res_push && (!fifo_full || rsp_pop);

   sync_fifo #(
      .WIDTH(FW),
      .DEPTH(FIFO_DEPTH)
   ) u_rsp_fifo (
      .clk   (clk),
      .arst_n(arst_n),
      .push  (fifo_push),
      .din   ({sh_id_q[PIPE_LAT], fpu_r}),
      .pop   (rsp_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign rsp_valid = !fifo_empty;
   assign rsp_id    = fifo_dout[FW-1:WIDTH];
   assign rsp_r     = fifo_dout[WIDTH-1:0];
   assign fpu_a     = fpu_a_q;
   assign fpu_b     = fpu_b_q;
   assign fpu_op    = fpu_op_q;
   assign busy      = (credit_q != CRW'(FIFO_DEPTH)) || (fifo_count != '0);

endmodule : fpu_addsub_arbiter

// File: tb/tb_fpu_addsub_arbiter.sv
// Directed bench for fpu_addsub_arbiter with a behavioural 5-stage add/sub
// datapath; handshakes and responses are logged on the falling edge.
module tb_fpu_addsub_arbiter;
   import fpu_pkg::*;

   localparam int WIDTH      = 32;
   localparam int NREQ       = 4;
   localparam int ID_W       = 2;
   localparam int PIPE_LAT   = 5;
   localparam int FIFO_DEPTH = 8;

   logic                  clk = 1'b0;
   logic                  arst_n;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;
   logic [NREQ-1:0]       req_op;
   logic [WIDTH-1:0]      fpu_a;
   logic [WIDTH-1:0]      fpu_b;
   logic                  fpu_op;
   logic [WIDTH-1:0]      fpu_r;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [ID_W-1:0]       rsp_id;
   logic [WIDTH-1:0]      rsp_r;
   logic                  busy;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   logic [31:0] hs_id[$], hs_cyc[$], rs_id[$], rs_r[$], rs_cyc[$];
   logic [WIDTH-1:0] dp_q [PIPE_LAT];

   always #5 clk = ~clk;

   fpu_addsub_arbiter #(
      .WIDTH(WIDTH), .NREQ(NREQ), .ID_W(ID_W),
      .PIPE_LAT(PIPE_LAT), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk(clk), .arst_n(arst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op),
      .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op), .fpu_r(fpu_r),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_r(rsp_r), .busy(busy)
   );

   // Known IEEE-754 results for the directed vectors; other operand sets get
   // a distinct substitute value so routing mistakes still show up.
   function automatic logic [31:0] dp_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic op);
      if (a == 32'h3F80_0000 && b == 32'h4000_0000 && op == OP_ADD) return 32'h4040_0000;
      if (a == 32'h4040_0000 && b == 32'h3F80_0000 && op == OP_SUB) return 32'h4000_0000;
      return a ^ {b[30:0], op};
   endfunction

   function automatic logic [31:0] da(input int i);
      return 32'h1000_0000 + 32'(i);
   endfunction

   function automatic logic [31:0] db(input int i);
      return 32'h0200_0000 * 32'(i + 1);
   endfunction

   function automatic logic [31:0] qat(input logic [31:0] q[$], input int k);
      if (k < q.size()) return q[k];
      return 32'hDEAD_BEEF;
   endfunction

   always @(posedge clk) begin
      dp_q[0] <= dp_model(fpu_a, fpu_b, fpu_op);
      for (int k = 1; k < PIPE_LAT; k++) dp_q[k] <= dp_q[k-1];
   end
   assign fpu_r = dp_q[PIPE_LAT-1];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      for (int i = 0; i < NREQ; i++) begin
         if (req_valid[i] && req_ready[i]) begin
            hs_id.push_back(32'(i));
            hs_cyc.push_back(32'(cyc));
            $display("[%0d] issue id=%0d", cyc, i);
         end
      end
      if (rsp_valid && rsp_ready) begin
         rs_id.push_back(32'(rsp_id));
         rs_r.push_back(rsp_r);
         rs_cyc.push_back(32'(cyc));
         $display("[%0d] response id=%0d r=%h", cyc, rsp_id, rsp_r);
      end
      assert (!(dut.res_push && dut.fifo_full && !(rsp_valid && rsp_ready))) else begin
         n_err++;
         $error("FAIL fifo_overflow: push into full FIFO at cycle %0d", cyc);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic nxt(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clr();
      hs_id.delete(); hs_cyc.delete();
      rs_id.delete(); rs_r.delete(); rs_cyc.delete();
   endtask

   task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic op);
      req_a[i*WIDTH +: WIDTH] = a;
      req_b[i*WIDTH +: WIDTH] = b;
      req_op[i]               = op;
   endtask

   task automatic set_defaults();
      for (int i = 0; i < NREQ; i++) set_op(i, da(i), db(i), 1'(i % 2));
   endtask

   initial begin
      arst_n    = 1'b0;
      req_valid = '1;
      rsp_ready = 1'b0;
      req_a = '0; req_b = '0; req_op = '0;
      set_defaults();

      // Reset state, with every requester asserting valid
      nxt(2); #2;
      chk("rst_req_ready", 32'(req_ready), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_fpu_a", fpu_a, 32'h0);
      chk("rst_fpu_op", 32'(fpu_op), 32'h0);
      chk("rst_rsp_id", 32'(rsp_id), 32'h0);
      chk("rst_rsp_r", rsp_r, 32'h0);

      nxt(1); arst_n = 1'b1; req_valid = '0; rsp_ready = 1'b1; clr();

      // Single add from requester 2
      nxt(1);
      set_op(2, 32'h3F80_0000, 32'h4000_0000, OP_ADD);
      req_valid = 4'b0100; #2;
      chk("add_ready", 32'(req_ready), 32'h4);
      nxt(1); req_valid = '0; #2;
      chk("add_fpu_a", fpu_a, 32'h3F80_0000);
      chk("add_fpu_b", fpu_b, 32'h4000_0000);
      chk("add_fpu_op", 32'(fpu_op), 32'h0);
      chk("add_busy", 32'(busy), 32'h1);
      nxt(12);
      chk("add_nrsp", 32'(rs_id.size()), 32'd1);
      chk("add_latency", qat(rs_cyc, 0) - qat(hs_cyc, 0), 32'd7);
      chk("add_id", qat(rs_id, 0), 32'd2);
      chk("add_r", qat(rs_r, 0), 32'h4040_0000);
      chk("add_idle", 32'(busy), 32'h0);

      // Single subtract from requester 0
      clr();
      set_op(0, 32'h4040_0000, 32'h3F80_0000, OP_SUB);
      req_valid = 4'b0001; #2;
      chk("sub_ready", 32'(req_ready), 32'h1);
      nxt(1); req_valid = '0;
      nxt(12);
      chk("sub_nrsp", 32'(rs_id.size()), 32'd1);
      chk("sub_latency", qat(rs_cyc, 0) - qat(hs_cyc, 0), 32'd7);
      chk("sub_id", qat(rs_id, 0), 32'd0);
      chk("sub_r", qat(rs_r, 0), 32'h4000_0000);

      // Fairness: all requesters valid for 8 cycles after a reset
      arst_n = 1'b0;
      nxt(1); arst_n = 1'b1; set_defaults(); clr();
      req_valid = '1;
      nxt(8); req_valid = '0;
      nxt(14);
      chk("fair_nissue", 32'(hs_id.size()), 32'd8);
      chk("fair_nrsp", 32'(rs_id.size()), 32'd8);
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("fair_grant%0d", k), qat(hs_id, k), 32'(k % 4));
         chk($sformatf("fair_cycle%0d", k), qat(hs_cyc, k) - qat(hs_cyc, 0), 32'(k));
         chk($sformatf("fair_rspid%0d", k), qat(rs_id, k), 32'(k % 4));
         chk($sformatf("fair_rspr%0d", k), qat(rs_r, k),
             dp_model(da(k % 4), db(k % 4), 1'(k % 2)));
         chk($sformatf("fair_lat%0d", k), qat(rs_cyc, k) - qat(hs_cyc, k), 32'd7);
      end

      // Backpressure: only FIFO_DEPTH accepts while responses are held
      clr();
      rsp_ready = 1'b0; req_valid = '1;
      nxt(20); #2;
      chk("bp_naccept", 32'(hs_id.size()), 32'd8);
      chk("bp_first", qat(hs_id, 0), 32'd0);
      chk("bp_last", qat(hs_id, 7), 32'd3);
      chk("bp_ready_zero", 32'(req_ready), 32'h0);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("bp_busy", 32'(busy), 32'h1);

      // One pop at credit 0: no grant that cycle, one grant the next
      nxt(1); rsp_ready = 1'b1; #2;
      chk("pop_cycle_ready", 32'(req_ready), 32'h0);
      nxt(1); rsp_ready = 1'b0; #2;
      chk("after_pop_ready", 32'(req_ready), 32'h1);
      nxt(1); #2;
      chk("refill_ready", 32'(req_ready), 32'h0);
      nxt(5);
      chk("bp_naccept_after", 32'(hs_id.size()), 32'd9);
      chk("bp_npop", 32'(rs_id.size()), 32'd1);
      chk("bp_pop_id", qat(rs_id, 0), 32'd0);

      // Drain
      req_valid = '0; rsp_ready = 1'b1;
      nxt(20);
      chk("drain_nrsp", 32'(rs_id.size()), 32'd9);
      chk("drain_id8", qat(rs_id, 8), 32'd0);
      chk("drain_r8", qat(rs_r, 8), dp_model(da(0), db(0), 1'b0));
      chk("drain_busy", 32'(busy), 32'h0);

      // Reset with three operations in flight
      clr();
      req_valid = '1;
      nxt(3); req_valid = '0; arst_n = 1'b0;
      nxt(1); arst_n = 1'b1; #2;
      chk("mid_nissue", 32'(hs_id.size()), 32'd3);
      chk("mid_busy", 32'(busy), 32'h0);
      chk("mid_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("mid_fpu_a", fpu_a, 32'h0);
      clr();
      nxt(10);
      chk("mid_no_rsp", 32'(rs_id.size()), 32'd0);
      set_op(2, 32'h3F80_0000, 32'h4000_0000, OP_ADD);
      req_valid = 4'b0100; #2;
      chk("post_ready", 32'(req_ready), 32'h4);
      nxt(1); req_valid = '0;
      nxt(12);
      chk("post_nrsp", 32'(rs_id.size()), 32'd1);
      chk("post_latency", qat(rs_cyc, 0) - qat(hs_cyc, 0), 32'd7);
      chk("post_id", qat(rs_id, 0), 32'd2);
      chk("post_r", qat(rs_r, 0), 32'h4040_0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_fpu_addsub_arbiter
